// File: rtl/cache_bus_responder_if.sv
// rtl/cache_bus_responder_if.sv - cache line-fill/writeback bus between cache (master) and memory responder (slave)
interface cache_bus_responder_if #(
  parameter int PA_BITS = 34,
  parameter int BEATLEN = 64,
  parameter int LINELEN = 512
) ();
  localparam int LOGBWPL = $clog2(LINELEN / BEATLEN);

  logic [1:0]         CacheBusRW;
  logic [PA_BITS-1:0] CacheBusAdr;
  logic [BEATLEN-1:0] WriteBeatData;
  logic [LOGBWPL-1:0] BeatCount;
  logic               SelBusBeat;
  logic [LINELEN-1:0] FetchBuffer;
  logic               CacheBusAck;
  logic               BusErr;

  modport master (
    output CacheBusRW, CacheBusAdr, WriteBeatData,
    input  BeatCount, SelBusBeat, FetchBuffer, CacheBusAck, BusErr
  );

  modport slave (
    input  CacheBusRW, CacheBusAdr, WriteBeatData,
    output BeatCount, SelBusBeat, FetchBuffer, CacheBusAck, BusErr
  );
endinterface

// File: rtl/cache_bus_responder.sv
// rtl/cache_bus_responder.sv - burst memory responder with beat storage and fixed wait latency
// Optional bubble injection from a 16-bit LFSR under `CACHE_BUS_RESPONDER_STALL_INJECT_EN.
module cache_bus_responder #(
  parameter int PA_BITS  = 34,
  parameter int BEATLEN  = 64,
  parameter int LINELEN  = 512,
  parameter int MEMBEATS = 4096,
  parameter int LATENCY  = 2
) (
  input  logic clk,
  input  logic reset,
  cache_bus_responder_if.slave bus
);
  localparam int BEATSPERLINE = LINELEN / BEATLEN;
  localparam int LOGBWPL      = $clog2(BEATSPERLINE);
  localparam int OFFS         = $clog2(LINELEN / 8);
  localparam int LINE_W       = $clog2(MEMBEATS / BEATSPERLINE);
  localparam int IDX_W        = $clog2(MEMBEATS);
  localparam int LAT_W        = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               fetch_q, fetch_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LOGBWPL-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               sel_q, sel_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [LINELEN-1:0] fbuf_q, fbuf_d;

  logic [BEATLEN-1:0] mem [MEMBEATS];
  logic [IDX_W-1:0]   idx;
  logic               xfer;
  logic               adr_unused;

  assign idx = {line_q, beat_q};
  // Address bits above the line index alias onto the storage (wrap).
  assign adr_unused = ^{bus.CacheBusAdr[PA_BITS-1:OFFS+LINE_W], bus.CacheBusAdr[OFFS-1:0]};

`ifdef CACHE_BUS_RESPONDER_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign xfer   = (state_q == S_BURST) && !lfsr_q[0];

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign xfer = (state_q == S_BURST);
`endif

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    line_d  = line_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    err_d   = err_q;
    fbuf_d  = fbuf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.CacheBusRW == 2'b10 || bus.CacheBusRW == 2'b01) begin
          fetch_d = bus.CacheBusRW[1];
          line_d  = bus.CacheBusAdr[OFFS +: LINE_W];
          lat_d   = '0;
          beat_d  = '0;
          state_d = (LATENCY == 0) ? S_BURST : S_WAIT;
        end else if (bus.CacheBusRW == 2'b11) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(LATENCY - 1)) state_d = S_BURST;
        else                               lat_d   = lat_q + LAT_W'(1);
      end
      S_BURST: begin
        if (xfer) begin
          if (fetch_q) fbuf_d[int'(beat_q) * BEATLEN +: BEATLEN] = mem[idx];
          if (beat_q == LOGBWPL'(BEATSPERLINE - 1)) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + LOGBWPL'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    sel_d = (state_d == S_BURST);
    ack_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fetch_q <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      fbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      fbuf_q  <= fbuf_d;
    end
  end

  // Storage is never cleared; a beat in flight when reset hits is not written.
  always_ff @(posedge clk) begin
    if (reset && xfer && !fetch_q) mem[idx] <= bus.WriteBeatData;
  end

  assign bus.BeatCount   = beat_q;
  assign bus.SelBusBeat  = sel_q;
  assign bus.FetchBuffer = fbuf_q;
  assign bus.CacheBusAck = ack_q;
  assign bus.BusErr      = err_q;
endmodule

// File: doc/cache_bus_responder.md
Name: cache_bus_responder

Overview:
- Memory-side responder for the cache line-fill/writeback bus: consumes CacheBusRW/CacheBusAdr and drives BeatCount, SelBusBeat, FetchBuffer and CacheBusAck.
- Backs requests with an internal beat-addressed storage array and configurable access latency.
- Serves as the burst-level memory model for I$/D$ unit benches and as the base for a simple on-chip memory controller.

Parameters:
PA_BITS, 34, physical address width
BEATLEN, 64, bits per bus beat
LINELEN, 512, cache line bits; BEATSPERLINE = LINELEN/BEATLEN, LOGBWPL = clog2(BEATSPERLINE)
MEMBEATS, 4096, storage depth in beats (power of 2)
LATENCY, 2, wait cycles between request acceptance and first beat (0 legal)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low (0 = reset)
CacheBusRW  input  2  [1] line fetch, [0] line writeback
CacheBusAdr  input  PA_BITS  line-aligned address
WriteBeatData  input  BEATLEN  writeback beat from cache, selected by BeatCount
BeatCount  output  LOGBWPL  current beat index
SelBusBeat  output  1  cache must select word by BeatCount
FetchBuffer  output  LINELEN  assembled fetched line
CacheBusAck  output  1  one-cycle completion pulse
BusErr  output  1  sticky illegal-request flag

Behaviour:
- Reset (reset==0 at edge): state IDLE, BeatCount=0, SelBusBeat=0, CacheBusAck=0, BusErr=0, FetchBuffer=0, latency counter=0. Storage array is not cleared.
- States: IDLE, WAIT, BURST, DONE.
- IDLE
  - CacheBusRW==10 or 01: latch op and line index = CacheBusAdr[clog2(LINELEN/8)+:...] modulo MEMBEATS/BEATSPERLINE (high bits ignored, wrap). Go to WAIT, or to BURST if LATENCY==0.
  - CacheBusRW==11: set BusErr, stay IDLE, no ack.
  - CacheBusRW==00: stay IDLE.
- WAIT: count LATENCY cycles, then BURST. BeatCount held at 0.
- BURST
  - SelBusBeat=1 for the whole state.
  - Each cycle handles beat BeatCount at storage index line*BEATSPERLINE+BeatCount.
  - Fetch: FetchBuffer[BeatCount*BEATLEN+:BEATLEN] <= mem[idx]. Storage read is combinational, captured at the edge.
  - Writeback: mem[idx] <= WriteBeatData, sampled in the same cycle.
  - BeatCount increments each beat. At BeatCount==BEATSPERLINE-1 it wraps to 0 and the state goes to DONE.
- DONE: CacheBusAck=1 for exactly this cycle; FetchBuffer is complete and stable. Next state IDLE.
- Latency: request seen in IDLE at cycle t gives CacheBusAck at cycle t+LATENCY+BEATSPERLINE+1.
- Commitment: once accepted, the burst always completes and acks even if CacheBusRW drops or changes mid-operation. Inputs other than WriteBeatData are ignored after acceptance.
- Back-to-back: a request still asserted in the IDLE cycle after DONE is a new request. The cache deasserts within the ack cycle.
- FetchBuffer holds its value between fetches. Writeback bursts leave it unchanged.
- Reset mid-operation: abort to IDLE with no ack. Storage beats already written stay written.
- Writeback then fetch of the same line returns the written data.

Optional Feature:
- Macro CACHE_BUS_RESPONDER_STALL_INJECT_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1) reset to 16'hACE1.
  - LFSR advances every cycle.
  - When lfsr[0]==1 in BURST, that cycle is a bubble: no beat transfer, BeatCount holds, SelBusBeat stays 1.
  - Ack latency becomes data-dependent but is deterministic from reset.
- Undefined: no LFSR logic, no bubbles, fixed latency as above.

Test Plan:
- Reset: drive reset=0 for 2 cycles with random inputs -> all outputs 0, state IDLE; CacheBusRW=00 for 20 cycles -> no ack.
- Fetch: preload beats 0..7 of line 3 with 64'h1111_0000+i; request 10 at adr line 3 -> ack exactly 11 cycles after acceptance (LATENCY=2, 8 beats); FetchBuffer beat i = 64'h1111_0000+i.
- Writeback then fetch: writeback line 5 with WriteBeatData=64'hDEAD_0000+BeatCount; then fetch line 5 -> identical data returned.
- Aliasing and commitment: fetch at adr with bits above index set -> returns the aliased line. Drop CacheBusRW to 00 at beat 3 -> burst completes, single ack.
- Reset mid-burst: reset=0 at beat 4 of a writeback -> IDLE with no ack; beats 0..3 updated, beats 4..7 unchanged.
- Illegal request and back-to-back: CacheBusRW=11 -> BusErr=1 sticky, no ack. Back-to-back fetch-to-fetch -> second acceptance in the cycle after the first ack.
